lcd_pattern_sequencer: RTL and testbench
========================================

// Module: lcd_pattern_sequencer
// PURPOSE
//  Selects which test pattern the LCD colour-pattern generator drives (H bars, V bars, gray, fractal).
//  Advances the selection on a debounced user key press or automatically every N frames.
//  Applies every change only on a frame boundary, so a frame never shows two patterns (no tearing).
//  Sits between the board key / LCD timing generator and the pattern generator's select input.
// PARAMETERS
//  NUM_PATTERNS        4        number of selectable patterns; pattern_sel range 0..NUM_PATTERNS-1
//  INIT_PATTERN        0        pattern_sel value after reset (must be < NUM_PATTERNS)
//  DEBOUNCE_CYC        20'd270000  clk cycles the key must stay stable to be accepted (~10 ms @27 MHz)
//  FRAMES_PER_PATTERN  120      frames per pattern in auto mode (>=1)
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  frame_start  in   1   one-cycle pulse at the start of each frame, synchronous to clk
//  key_n        in   1   raw user key, active-low, asynchronous, bouncy
//  auto_en      in   1   1 = auto-advance every FRAMES_PER_PATTERN frames; synchronous level
//  pattern_sel  out  2   current pattern index to the pattern generator (registered)
//  sel_update   out  1   one-cycle pulse, high in the first cycle a new pattern_sel value is visible
//  key_pending  out  1   a key advance is waiting for the next frame_start (registered)
// BEHAVIOUR
//  Reset (async, all regs): pattern_sel=INIT_PATTERN, sel_update=0, key_pending=0, frame_cnt=0,
//   sync flops=1 (released), debounce FSM=KEY_UP, debounce counter=0.
//  Key path: 2-flop synchronizer on key_n -> key_s. Debounce FSM (4 states):
//   KEY_UP: key_s==0 -> DOWN_WAIT, cnt=0.
//   DOWN_WAIT: key_s==1 -> KEY_UP; else cnt++; cnt==DEBOUNCE_CYC-1 -> KEY_DOWN, emit key_press (1 cycle).
//   KEY_DOWN: key_s==1 -> UP_WAIT, cnt=0.
//   UP_WAIT: key_s==0 -> KEY_DOWN; else cnt++; cnt==DEBOUNCE_CYC-1 -> KEY_UP.
//   Exactly one key_press per accepted press; holding the key never repeats.
//  Pending: key_press sets key_pending; it is cleared only by the frame_start that consumes it.
//   Multiple presses inside one frame coalesce to one advance.
//   key_press and frame_start in the same cycle: that frame_start does not consume it;
//   key_pending=1, and the advance happens at the next frame_start.
//  Auto timer: auto_en=0 -> frame_cnt held at 0. auto_en=1 -> frame_cnt++ on each frame_start;
//   auto_due = frame_start && frame_cnt==FRAMES_PER_PATTERN-1.
//  Advance: on a clk edge with frame_start=1 and (key_pending || auto_due):
//   pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1; frame_cnt<=0; key_pending<=0.
//   Key and auto_due on the same frame_start -> a single +1 advance only.
//   A key advance also restarts the auto count (frame_cnt<=0).
//  Latency: new pattern_sel is visible the cycle after the frame_start edge. sel_update is high for
//   exactly that cycle and is 0 at all other times. Never change pattern_sel outside frame_start.
//  frame_start with no advance: pattern_sel and sel_update (=0) unchanged.
//  auto_en falling mid-count: frame_cnt clears next cycle; rising: counting restarts from 0.
//  Reset mid-operation: all state returns to reset values immediately; a pending key is discarded.
//  Width: pattern_sel is 2 bits (NUM_PATTERNS<=4); frame_cnt and debounce counter are sized by $clog2.
// TESTING
//  1 Reset, auto_en=0, key idle, 10 frame_starts -> pattern_sel stays 0, sel_update never pulses.
//  2 key_n low 300000 cycles with 5 bounces in the first 1000 -> exactly one key_press, key_pending=1;
//    next frame_start -> pattern_sel 0->1, sel_update 1 cycle, key_pending=0.
//  3 Four accepted presses, each in a separate frame -> pattern_sel 1,2,3,0 (wrap at NUM_PATTERNS-1).
//  4 key_press in the same cycle as frame_start -> no change at that frame_start; advance at the next one.
//  5 auto_en=1, FRAMES_PER_PATTERN=3 (override) -> advance on every 3rd frame_start; a key pending on
//    the 3rd frame -> single +1 advance, frame_cnt=0.
//  6 rst_n pulsed low while key_pending=1 and pattern_sel=2 -> pattern_sel=0 and key_pending=0
//    asynchronously; the next frame_start does not advance.

Source files
------------

// File: rtl/lcd_pattern_sequencer.sv
// Test-pattern selector for the LCD colour-pattern generator: debounced key and
// auto-advance requests are held until a frame boundary so a frame never tears.
module lcd_pattern_sequencer #(
  parameter int unsigned NUM_PATTERNS       = 4,
  parameter int unsigned INIT_PATTERN       = 0,
  parameter int unsigned DEBOUNCE_CYC       = 20'd270000,
  parameter int unsigned FRAMES_PER_PATTERN = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       key_n,
  input  logic       auto_en,
  output logic [1:0] pattern_sel,
  output logic       sel_update,
  output logic       key_pending
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned FC_W = (FRAMES_PER_PATTERN > 32'd1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 32'd1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1'b1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 32'd1);
  localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1'b1);
  localparam logic [1:0]      PAT_LAST = 2'(NUM_PATTERNS - 32'd1);
  localparam logic [1:0]      PAT_INIT = 2'(INIT_PATTERN);

  typedef enum logic [1:0] {
    KEY_UP    = 2'd0,
    DOWN_WAIT = 2'd1,
    KEY_DOWN  = 2'd2,
    UP_WAIT   = 2'd3
  } db_state_t;

  logic            sync_meta_r;
  logic            sync_r;
  logic            key_s;
  db_state_t       db_state_r;
  db_state_t       db_state_nxt;
  logic [DB_W-1:0] db_cnt_r;
  logic [DB_W-1:0] db_cnt_nxt;
  logic            key_press;
  logic [FC_W-1:0] frame_cnt_r;
  logic            auto_due;
  logic            advance;
  logic [1:0]      sel_next;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
    end else begin
      sync_meta_r <= key_n;
      sync_r      <= sync_meta_r;
    end
  end

  assign key_s = sync_r;

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state_r <= KEY_UP;
      db_cnt_r   <= {DB_W{1'b0}};
    end else begin
      db_state_r <= db_state_nxt;
      db_cnt_r   <= db_cnt_nxt;
    end
  end

  // Debounce next state: a level must persist DEBOUNCE_CYC cycles before it is believed.
  always_comb begin
    db_state_nxt = db_state_r;
    db_cnt_nxt   = db_cnt_r;
    case (db_state_r)
      KEY_UP: begin
        if (!key_s) begin
          db_state_nxt = DOWN_WAIT;
          db_cnt_nxt   = {DB_W{1'b0}};
        end else begin
          db_state_nxt = KEY_UP;
        end
      end
      DOWN_WAIT: begin
        if (key_s) begin
          db_state_nxt = KEY_UP;
        end else if (db_cnt_r == DB_LAST) begin
          db_state_nxt = KEY_DOWN;
        end else begin
          db_cnt_nxt = db_cnt_r + DB_ONE;
        end
      end
      KEY_DOWN: begin
        if (key_s) begin
          db_state_nxt = UP_WAIT;
          db_cnt_nxt   = {DB_W{1'b0}};
        end else begin
          db_state_nxt = KEY_DOWN;
        end
      end
      UP_WAIT: begin
        if (!key_s) begin
          db_state_nxt = KEY_DOWN;
        end else if (db_cnt_r == DB_LAST) begin
          db_state_nxt = KEY_UP;
        end else begin
          db_cnt_nxt = db_cnt_r + DB_ONE;
        end
      end
      default: begin
        db_state_nxt = KEY_UP;
        db_cnt_nxt   = {DB_W{1'b0}};
      end
    endcase
  end

  // Debounce output: one pulse on the DOWN_WAIT -> KEY_DOWN transition only.
  always_comb begin
    if ((db_state_r == DOWN_WAIT) && !key_s && (db_cnt_r == DB_LAST)) begin
      key_press = 1'b1;
    end else begin
      key_press = 1'b0;
    end
  end

  // Advance only on frame_start; the pending flag is the registered value, so a
  // press landing on the same edge waits for the following frame.
  always_comb begin
    auto_due = auto_en && frame_start && (frame_cnt_r == FC_LAST);
    advance  = frame_start && (key_pending || auto_due);
    if (pattern_sel == PAT_LAST) begin
      sel_next = 2'd0;
    end else begin
      sel_next = pattern_sel + 2'd1;
    end
  end

  // Auto-advance frame counter; held at zero while auto mode is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= {FC_W{1'b0}};
    end else if (advance || !auto_en) begin
      frame_cnt_r <= {FC_W{1'b0}};
    end else if (frame_start) begin
      frame_cnt_r <= frame_cnt_r + FC_ONE;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Pending key request: set by a press, cleared by the frame_start that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pending <= 1'b0;
    end else if (key_press) begin
      key_pending <= 1'b1;
    end else if (advance) begin
      key_pending <= 1'b0;
    end else begin
      key_pending <= key_pending;
    end
  end

  // Pattern select and its one-cycle update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_sel <= PAT_INIT;
      sel_update  <= 1'b0;
    end else if (advance) begin
      pattern_sel <= sel_next;
      sel_update  <= 1'b1;
    end else begin
      pattern_sel <= pattern_sel;
      sel_update  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Scoreboard bench for lcd_pattern_sequencer: frames push expected selections,
// a monitor pops them whenever sel_update is seen.
module tb_lcd_pattern_sequencer;

  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic [1:0] pattern_sel;
  logic       sel_update;
  logic       key_pending;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_sel;
  logic [1:0] tbl[4] = '{2'd2, 2'd3, 2'd0, 2'd1};

  lcd_pattern_sequencer #(
    .NUM_PATTERNS(4), .INIT_PATTERN(0), .DEBOUNCE_CYC(DB), .FRAMES_PER_PATTERN(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .key_n(key_n),
    .auto_en(auto_en), .pattern_sel(pattern_sel), .sel_update(sel_update),
    .key_pending(key_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every sel_update must match the oldest expected selection.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sel_update) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_update: got pattern_sel %0d, expected no update", pattern_sel);
        end else begin
          check("sb_pattern_sel", pattern_sel, exp_q.pop_front());
        end
      end else if (pattern_sel !== prev_sel) begin
        check("sel_change_without_update", pattern_sel, prev_sel);
      end
    end
    prev_sel = pattern_sel;
  end

  task automatic frame(input bit adv, input logic [1:0] exp, input string name);
    if (adv) exp_q.push_back(exp);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check({name, "_upd"}, sel_update, adv);
    check({name, "_sel"}, pattern_sel, exp);
    @(negedge clk);
    check({name, "_upd_off"}, sel_update, 1'b0);
  endtask

  task automatic set_key(input logic v, input int cyc);
    @(posedge clk); #1 key_n = v;
    repeat (cyc) @(posedge clk);
  endtask

  task automatic key_down(input int bounces);
    for (int b = 0; b < bounces; b++) begin
      set_key(1'b0, 3);
      set_key(1'b1, 3);
    end
    set_key(1'b0, DB + 10);
  endtask

  task automatic press();
    key_down(0);
    set_key(1'b1, DB + 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", pattern_sel, 2'd0);
    check("rst_upd", sel_update, 1'b0);
    check("rst_pend", key_pending, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle frames never advance.
    for (int i = 0; i < 10; i++) frame(1'b0, 2'd0, "idle");

    // Bouncy press, one advance, holding does not repeat.
    key_down(5);
    @(negedge clk);
    check("t2_pend", key_pending, 1'b1);
    check("t2_sel_before", pattern_sel, 2'd0);
    frame(1'b1, 2'd1, "t2_adv");
    check("t2_pend_clr", key_pending, 1'b0);
    set_key(1'b0, 3 * DB);
    @(negedge clk);
    check("t2_hold_norepeat", key_pending, 1'b0);
    set_key(1'b1, DB + 10);
    @(negedge clk);
    check("t2_release", key_pending, 1'b0);

    // One press per frame, with wrap.
    for (int i = 0; i < 4; i++) begin
      press();
      @(negedge clk);
      check("t3_pend", key_pending, 1'b1);
      frame(1'b1, tbl[i], "t3_adv");
    end

    // Two presses in one frame coalesce.
    press();
    press();
    frame(1'b1, 2'd2, "coalesce_adv");
    frame(1'b0, 2'd2, "coalesce_none");

    // key_press coincident with frame_start.
    @(posedge clk); #1 key_n = 1'b0;
    repeat (18) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    check("t4_upd", sel_update, 1'b0);
    check("t4_sel", pattern_sel, 2'd2);
    check("t4_pend", key_pending, 1'b1);
    set_key(1'b1, DB + 10);
    frame(1'b1, 2'd3, "t4_next");

    // Auto mode, every third frame.
    @(posedge clk); #1 auto_en = 1'b1;
    frame(1'b0, 2'd3, "auto"); frame(1'b0, 2'd3, "auto"); frame(1'b1, 2'd0, "auto_adv");
    frame(1'b0, 2'd0, "auto"); frame(1'b0, 2'd0, "auto"); frame(1'b1, 2'd1, "auto_adv");
    frame(1'b0, 2'd1, "auto"); frame(1'b0, 2'd1, "auto");
    press();
    frame(1'b1, 2'd2, "auto_key_same");
    frame(1'b0, 2'd2, "auto"); frame(1'b0, 2'd2, "auto"); frame(1'b1, 2'd3, "auto_restart");
    frame(1'b0, 2'd3, "auto");
    press();
    frame(1'b1, 2'd0, "auto_key_adv");
    frame(1'b0, 2'd0, "auto"); frame(1'b0, 2'd0, "auto"); frame(1'b1, 2'd1, "auto_after_key");
    frame(1'b0, 2'd1, "auto"); frame(1'b0, 2'd1, "auto");
    @(posedge clk); #1 auto_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 auto_en = 1'b1;
    frame(1'b0, 2'd1, "auto_toggle"); frame(1'b0, 2'd1, "auto_toggle");
    frame(1'b1, 2'd2, "auto_toggle_adv");

    // Asynchronous reset discards a pending key.
    @(posedge clk); #1 auto_en = 1'b0;
    key_down(0);
    @(negedge clk);
    check("t6_pend_set", key_pending, 1'b1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("t6_rst_sel", pattern_sel, 2'd0);
    check("t6_rst_pend", key_pending, 1'b0);
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    frame(1'b0, 2'd0, "t6_after_rst");
    check("t6_pend_after", key_pending, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
